// File: rtl/period_cnt.sv
// Programmable-period up-counter with sticky wrap flag.
// Timebase for PWM: counts 0..top inclusive, free-run or one-shot.
module period_cnt #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] top,
  input  logic             clr_it,
  input  logic             start,
  input  logic             freerun,
  output logic [width-1:0] cnt,
  output logic             it
);

  logic [width-1:0] cnt_q, cnt_d;
  logic             it_q, it_d;
  logic             run_q, run_d;
  logic             active;
  logic             wrap;

  assign active = freerun ? start : (run_q | start);
  // >= so a lowered top below the live count wraps at once
  assign wrap   = active && (cnt_q >= top);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    it_d  = it_q;
    if (active) begin
      cnt_d = wrap ? '0 : cnt_q + width'(1);
      run_d = !wrap;
    end
    if (wrap) begin
      it_d = 1'b1;
    end else if (clr_it) begin
      it_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      it_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      it_q  <= it_d;
      run_q <= run_d;
    end
  end

  assign cnt = cnt_q;
  assign it  = it_q;

endmodule

// File: tb/tb_period_cnt.sv
// Self-checking bench for period_cnt.
// Random and directed stimulus against a rule-level model.
module tb_period_cnt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] top = 32'd50;
  logic        clr_it = 1'b0;
  logic        start = 1'b0;
  logic        freerun = 1'b1;
  logic [31:0] cnt;
  logic        it;
  logic [7:0]  top8 = 8'd255;
  logic [7:0]  cnt8;
  logic        it8;

  int n_pass = 0;
  int n_total = 0;

  longint unsigned m_cnt = 0;
  bit m_it = 0;
  bit m_run = 0;

  period_cnt #(.width(32)) dut (
    .clk(clk), .rst(rst), .top(top), .clr_it(clr_it),
    .start(start), .freerun(freerun), .cnt(cnt), .it(it)
  );

  period_cnt #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .top(top8), .clr_it(clr_it),
    .start(start), .freerun(freerun), .cnt(cnt8), .it(it8)
  );

  always #5 clk = ~clk;

  // Rule-level model, evaluated with the inputs seen at the edge.
  task automatic model_edge();
    bit act;
    if (rst) begin
      m_cnt = 0;
      m_it  = 0;
      m_run = 0;
    end else begin
      act = freerun ? start : (m_run || start);
      if (act && m_cnt >= longint'(top)) begin
        m_cnt = 0;
        m_it  = 1;
        m_run = 0;
      end else begin
        if (act) begin
          m_cnt = m_cnt + 1;
          m_run = 1;
        end
        if (clr_it) m_it = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; freerun = 1; start = 1; top = 50; clr_it = 0;
    tick();
    rst = 0;
    n_total++;
    if (cnt !== 32'd0 || it !== 1'b0)
      $display("FAIL reset_init cnt=%0d it=%0b want 0/0", cnt, it);
    else n_pass++;
    repeat (7) tick();
    n_total++;
    if (cnt !== 32'd7)
      $display("FAIL reset_pre cnt=%0d want 7", cnt);
    else n_pass++;
    rst = 1;
    tick();
    rst = 0;
    n_total++;
    if (cnt !== 32'd0 || it !== 1'b0)
      $display("FAIL reset_mid cnt=%0d it=%0b want 0/0", cnt, it);
    else n_pass++;
    tick();
    n_total++;
    if (cnt !== 32'd1)
      $display("FAIL reset_resume cnt=%0d want 1", cnt);
    else n_pass++;
  endtask

  task automatic test_freerun_period();
    int bad;
    rst = 1; tick(); rst = 0;
    top = 50; start = 1; freerun = 1; clr_it = 0;
    bad = 0;
    for (int k = 1; k <= 102; k++) begin
      tick();
      if (cnt !== 32'(k % 51) || it !== (k >= 51)) begin
        if (bad == 0)
          $display("FAIL period k=%0d cnt=%0d it=%0b want %0d/%0b",
                   k, cnt, it, k % 51, k >= 51);
        bad++;
      end
    end
    n_total++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_clear();
    int ones;
    repeat (5) tick();
    n_total++;
    if (it !== 1'b1)
      $display("FAIL clr_pre it=%0b want 1", it);
    else n_pass++;
    clr_it = 1;
    tick();
    clr_it = 0;
    n_total++;
    if (it !== 1'b0)
      $display("FAIL clr_pulse it=%0b want 0", it);
    else n_pass++;
    clr_it = 1; top = 4;
    repeat (10) tick();
    ones = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (it === 1'b1) ones++;
      n_total++;
      if (it !== m_it || it !== (cnt == 0))
        $display("FAIL clr_prio cnt=%0d it=%0b want it=%0b", cnt, it, m_it);
      else n_pass++;
    end
    n_total++;
    if (ones != 4)
      $display("FAIL clr_pulses got %0d want 4", ones);
    else n_pass++;
    clr_it = 0;
  endtask

  task automatic test_pause();
    rst = 1; tick(); rst = 0;
    top = 100; start = 1; freerun = 1;
    repeat (30) tick();
    start = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_total++;
      if (cnt !== 32'd30)
        $display("FAIL pause_hold cnt=%0d want 30", cnt);
      else n_pass++;
    end
    start = 1;
    tick();
    n_total++;
    if (cnt !== 32'd31)
      $display("FAIL pause_resume cnt=%0d want 31", cnt);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    int exp [0:7];
    exp = '{1, 2, 3, 4, 5, 0, 0, 0};
    rst = 1; tick(); rst = 0;
    freerun = 0; top = 5; clr_it = 0;
    for (int r = 0; r < 2; r++) begin
      start = 1;
      for (int k = 0; k < 8; k++) begin
        tick();
        start = 0;
        n_total++;
        if (cnt !== 32'(exp[k]) || it !== (k >= 5 || r > 0))
          $display("FAIL oneshot r=%0d k=%0d cnt=%0d it=%0b want %0d",
                   r, k, cnt, it, exp[k]);
        else n_pass++;
      end
    end
    start = 1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_total++;
      if (cnt !== 32'(k % 6))
        $display("FAIL b2b k=%0d cnt=%0d want %0d", k, cnt, k % 6);
      else n_pass++;
    end
    start = 0;
  endtask

  task automatic test_top_bounds();
    rst = 1; tick(); rst = 0;
    freerun = 1; start = 1; top = 0;
    for (int k = 0; k < 4; k++) begin
      clr_it = (k == 2);
      tick();
      n_total++;
      if (cnt !== 32'd0 || it !== 1'b1)
        $display("FAIL top0 cnt=%0d it=%0b want 0/1", cnt, it);
      else n_pass++;
    end
    clr_it = 1;
    top = 50;
    tick();
    clr_it = 0;
    repeat (19) tick();
    n_total++;
    if (cnt !== 32'd20 || it !== 1'b0)
      $display("FAIL lower_pre cnt=%0d it=%0b want 20/0", cnt, it);
    else n_pass++;
    top = 10;
    tick();
    n_total++;
    if (cnt !== 32'd0 || it !== 1'b1)
      $display("FAIL lower_top cnt=%0d it=%0b want 0/1", cnt, it);
    else n_pass++;
  endtask

  task automatic test_width8();
    rst = 1; tick(); rst = 0;
    freerun = 1; start = 1; clr_it = 0;
    repeat (255) tick();
    n_total++;
    if (cnt8 !== 8'd255 || it8 !== 1'b0)
      $display("FAIL w8_top cnt=%0d it=%0b want 255/0", cnt8, it8);
    else n_pass++;
    tick();
    n_total++;
    if (cnt8 !== 8'd0 || it8 !== 1'b1)
      $display("FAIL w8_wrap cnt=%0d it=%0b want 0/1", cnt8, it8);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 2000; k++) begin
      top     = 32'($urandom_range(0, 12));
      start   = ($urandom_range(0, 3) != 0);
      clr_it  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 40) == 0) freerun = ~freerun;
      rst     = ($urandom_range(0, 150) == 0);
      tick();
      if (longint'(cnt) != m_cnt || it !== m_it) begin
        if (bad < 5)
          $display("FAIL random k=%0d cnt=%0d it=%0b want %0d/%0b",
                   k, cnt, it, m_cnt, m_it);
        bad++;
      end
    end
    rst = 0;
    n_total++;
    if (bad == 0) n_pass++;
  endtask

  initial begin
    test_reset();
    test_freerun_period();
    test_clear();
    test_pause();
    test_oneshot();
    test_top_bounds();
    test_width8();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/period_cnt.md
Name: period_cnt

Overview:
- Programmable-period up-counter with a sticky wrap flag.
- Counts 0..top inclusive, so the period is top+1 enabled cycles, then returns to 0.
- Serves as the timebase for PWM generators: the parent compares `cnt` against duty thresholds and against `top`.
- Supports free-running and one-shot modes. Synthesizable, single clock domain; simulation clock sources are not part of this block.

Parameters:
- width, 32, bit width of `top` and `cnt`.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- top  input  width  terminal count, inclusive; may change at any time and is used combinationally each cycle.
- clr_it  input  1  level; clears the `it` flag.
- start  input  1  run enable (free-run) / trigger (one-shot).
- freerun  input  1  1 = wrap and keep counting; 0 = one-shot.
- cnt  output  width  current count, registered.
- it  output  1  sticky wrap/terminal flag, registered.

Behaviour:
- Reset (rst=1 at posedge): cnt=0, it=0, running=0. Reset takes priority over everything and is applied mid-operation on the next edge.
- Internal state: running (1 bit), used only in one-shot mode.
- Enable: active = freerun ? start : (running | start).
- Counting rules, per posedge:
  - active and cnt < top: cnt <= cnt+1.
  - active and cnt >= top (wrap event): cnt <= 0. The >= guards against `top` being lowered below the current count.
  - not active: cnt holds (free-run pause).
- One-shot (freerun=0):
  - idle with start=1: running <= 1 and counting begins in the same cycle (cnt 0->1).
  - On the wrap event: running <= 0 and cnt <= 0.
  - If start is still 1 on the following cycle, a new run starts immediately.
  - start is ignored while running.
- Free-run (freerun=1): running is don't-care. Counts continuously while start=1 and pauses, holding value, while start=0.
- Flag `it`:
  - Set to 1 on every wrap event.
  - Cleared when clr_it=1.
  - If set and clear occur in the same cycle, set wins, so no event is lost. With clr_it tied high, `it` becomes a 1-cycle pulse on the cycle after cnt==top.
  - Otherwise `it` holds.
- top=0: cnt stays 0 and every active cycle is a wrap event, so `it` sets each active cycle.
- Arithmetic is unsigned, width bits. cnt never exceeds max(top, previous cnt) and never wraps through 2^width.
- Switching freerun mid-count takes effect the same cycle. Going 0->1 keeps the current cnt.
- No combinational path from inputs to outputs.
- Latency: cnt and it reflect input changes one clock after sampling.

Test Plan:
1. Reset: run free mode, then rst=1 for 1 cycle at cnt=7 -> next edge cnt=0, it=0. rst=0, start=1, freerun=1, top=50 -> cnt 1,2,...
2. Free-run period: top=50, start=1, freerun=1, clr_it=0 -> cnt sequence 0..50, 0..50 (period 51). `it` rises on the cycle cnt returns 0 after 50 and stays 1.
3. Clear/priority: with it=1, pulse clr_it one cycle mid-count -> it=0 next edge. clr_it held 1, top=4 -> it=1 for exactly one cycle every 5 cycles (set beats clear).
4. Pause: free-run top=100, drop start at cnt=30 for 10 cycles -> cnt holds 30, then resumes 31.
5. One-shot: freerun=0, top=5, 1-cycle start pulse -> cnt 1,2,3,4,5,0 then holds 0. it=1 after the wrap. A second pulse repeats the run. Start held high -> back-to-back runs.
6. Top boundaries:
   - top=0, free-run -> cnt stays 0, it=1.
   - Lower top from 50 to 10 while cnt=20 -> next edge cnt=0 and it set.
   - width=8, top=255 -> cnt reaches 255 and then 0, with no overflow artefact.
